// File: rtl/adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : adder_subtractor
// Brief    : Registered two's-complement ripple adder/subtractor with flags.
// Revision : 1.0 - initial release
// ============================================================================
module adder_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             negative
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic             w_overflow;

    logic             r_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_overflow;
    logic             r_carry;
    logic             r_zero;
    logic             r_negative;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign w_bx   = b ^ {WIDTH{sub}};
    assign w_c[0] = sub;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign w_sum[gi]  = a[gi] ^ w_bx[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a[gi] & w_bx[gi]) | (w_c[gi] & (a[gi] ^ w_bx[gi]));
        end
    endgenerate

    assign w_overflow = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_s        <= '0;
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b1;
            r_negative <= 1'b0;
        end else begin
            r_valid <= in_valid;
            // Result and flags hold their last value across idle cycles.
            if (in_valid) begin
                r_s        <= w_sum;
                r_overflow <= w_overflow;
                r_carry    <= w_c[WIDTH];
                r_zero     <= (w_sum == '0);
                r_negative <= w_sum[WIDTH-1];
            end
        end
    end

    assign out_valid = r_valid;
    assign s         = r_s;
    assign overflow  = r_overflow;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign negative  = r_negative;

endmodule
`default_nettype wire

// File: tb/tb_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_subtractor
// Brief    : Vector table, corner sequences and random checks for adder_subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             overflow;
    logic             carry;
    logic             zero;
    logic             negative;

    int n_vec;
    int n_err;

    adder_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .s         (s),
        .overflow  (overflow),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vsub;
        logic [7:0] es;
        logic       eovf;
        logic       ecarry;
        logic       ezero;
        logic       eneg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference computed from signed/unsigned integer arithmetic.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic msub,
                         output logic [7:0] ms, output logic movf, output logic mcarry,
                         output logic mzero, output logic mneg);
        int sa, sb, ua, ub, t;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ua = int'({24'd0, ma});
        ub = int'({24'd0, mb});
        t  = msub ? (sa - sb) : (sa + sb);
        ms     = t[7:0];
        movf   = (t > 127) || (t < -128);
        mcarry = msub ? (ua >= ub) : ((ua + ub) > 255);
        mzero  = (ms == 8'd0);
        mneg   = ms[7];
    endtask

    task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vsub, input logic vv);
        @(negedge clk);
        a = va; b = vb; sub = vsub; in_valid = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [7:0] es,
                             input logic eo, input logic ec, input logic ez, input logic en);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".s"},         32'(s),         32'(es));
        check({tag, ".overflow"},  32'(overflow),  32'(eo));
        check({tag, ".carry"},     32'(carry),     32'(ec));
        check({tag, ".zero"},      32'(zero),      32'(ez));
        check({tag, ".negative"},  32'(negative),  32'(en));
    endtask

    initial begin
        vec_t       tbl[9];
        logic [7:0] ms, la, lb;
        logic       mo, mc, mz, mn, ls;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;

        tbl[0] = '{8'd5,   8'd3,   1'b0, 8'd8,   1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'd5,   8'd5,   1'b1, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h00,  8'h00,  1'b0, 8'h00,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h80,  8'h00,  1'b1, 8'h80,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'h00,  8'h01,  1'b1, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{8'hFF,  8'hFF,  1'b0, 8'hFE,  1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].va, tbl[i].vb, tbl[i].vsub, 1'b1);
            check_all($sformatf("tbl%0d", i), 1'b1, tbl[i].es, tbl[i].eovf,
                      tbl[i].ecarry, tbl[i].ezero, tbl[i].eneg);
        end

        // Idle after -1 + -1: out_valid drops, result and flags hold.
        drive(8'h12, 8'h34, 1'b1, 1'b0);
        check_all("hold", 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset between edges while out_valid is high.
        drive(8'd20, 8'd7, 1'b0, 1'b1);
        check("prereset.out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'd100, 8'd56, 1'b1, 1'b1);
        check_all("post_rst", 1'b1, 8'd44, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional idle cycles; idle cycles expect held values.
        for (int i = 0; i < 60; i++) begin
            la = 8'($urandom);
            lb = 8'($urandom);
            ls = 1'(i % 2);
            drive(la, lb, ls, 1'b1);
            model(la, lb, ls, ms, mo, mc, mz, mn);
            check_all($sformatf("rnd%0d", i), 1'b1, ms, mo, mc, mz, mn);
            if ($urandom_range(3) == 0) begin
                drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
                check_all($sformatf("idle%0d", i), 1'b0, ms, mo, mc, mz, mn);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
